// File: rtl/rx_data_sampler_if.sv
// Bundle of UART RX sampler signals shared between the RX FSM (master) and the sampler (slave).
interface rx_data_sampler_if;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       dat_samp_en;
  logic       sampled_bit;
  logic       sample_valid;
  logic [3:0] bit_cnt;
  logic [5:0] edge_cnt;
  logic       frame_done;

  modport master (
    output RX_IN, Prescale, PAR_EN, dat_samp_en,
    input  sampled_bit, sample_valid, bit_cnt, edge_cnt, frame_done
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, dat_samp_en,
    output sampled_bit, sample_valid, bit_cnt, edge_cnt, frame_done
  );
endinterface

// File: rtl/rx_data_sampler.sv
// UART RX oversampling data sampler: tick/bit counters, mid-bit sampling and frame-end pulse.
// Define RX_SAMPLER_MAJORITY_EN for 2-of-3 majority voting around the bit centre.
module rx_data_sampler (
  input  logic              CLK,
  input  logic              RST,
  rx_data_sampler_if.slave  bus
);

  logic [5:0] r_prescale;
  logic       r_par_en;
  logic [5:0] r_edge_cnt;
  logic [3:0] r_bit_cnt;
  logic       r_sampled_bit;
  logic       r_sample_valid;
  logic       r_frame_done;

  logic [5:0] w_p;
  logic [5:0] w_half;
  logic [3:0] w_last_bit;
  logic       w_edge_wrap;
  logic       w_frame_end;
  logic       w_sample_tick;
  logic       w_sample_val;

  // Unsupported ratios fall back to 8 so the counters always see a legal period.
  always_comb begin
    w_p = 6'd8;
    if (r_prescale == 6'd16 || r_prescale == 6'd32) begin
      w_p = r_prescale;
    end
  end

  assign w_half      = w_p >> 1;
  assign w_last_bit  = r_par_en ? 4'd10 : 4'd9;
  assign w_edge_wrap = (r_edge_cnt >= w_p - 6'd1);
  assign w_frame_end = w_edge_wrap && (r_bit_cnt == w_last_bit);

`ifdef RX_SAMPLER_MAJORITY_EN
  logic r_vote_lo;
  logic r_vote_mid;

  // The third vote is taken straight from the line on the deciding edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vote_lo  <= 1'b0;
      r_vote_mid <= 1'b0;
    end else if (bus.dat_samp_en) begin
      if (r_edge_cnt == w_half - 6'd1) begin
        r_vote_lo <= bus.RX_IN;
      end
      if (r_edge_cnt == w_half) begin
        r_vote_mid <= bus.RX_IN;
      end
    end
  end

  assign w_sample_tick = (r_edge_cnt == w_half + 6'd1);
  assign w_sample_val  = (r_vote_lo & r_vote_mid) | (r_vote_lo & bus.RX_IN) |
                         (r_vote_mid & bus.RX_IN);
`else
  assign w_sample_tick = (r_edge_cnt == w_half);
  assign w_sample_val  = bus.RX_IN;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prescale     <= 6'd8;
      r_par_en       <= 1'b0;
      r_edge_cnt     <= 6'd0;
      r_bit_cnt      <= 4'd0;
      r_sampled_bit  <= 1'b0;
      r_sample_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end else if (!bus.dat_samp_en) begin
      r_prescale     <= bus.Prescale;
      r_par_en       <= bus.PAR_EN;
      r_edge_cnt     <= 6'd0;
      r_bit_cnt      <= 4'd0;
      r_sample_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_edge_cnt <= w_edge_wrap ? 6'd0 : r_edge_cnt + 6'd1;
      if (w_edge_wrap) begin
        r_bit_cnt <= (r_bit_cnt >= w_last_bit) ? 4'd0 : r_bit_cnt + 4'd1;
      end
      r_frame_done   <= w_frame_end;
      r_sample_valid <= w_sample_tick;
      if (w_sample_tick) begin
        r_sampled_bit <= w_sample_val;
      end
    end
  end

  assign bus.sampled_bit  = r_sampled_bit;
  assign bus.sample_valid = r_sample_valid;
  assign bus.bit_cnt      = r_bit_cnt;
  assign bus.edge_cnt     = r_edge_cnt;
  assign bus.frame_done   = r_frame_done;

endmodule

// File: tb/tb_rx_data_sampler.sv
// Randomised scoreboard bench for rx_data_sampler; follows RX_SAMPLER_MAJORITY_EN like the design.
module tb_rx_data_sampler;

  typedef struct {
    int         cycle;
    logic       value;
    logic [3:0] bitIdx;
    logic [5:0] edgeIdx;
  } sample_t;

  logic CLK = 1'b0;
  logic RST;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic lastBit = 1'b0;

  sample_t expQ[$];
  int      doneQ[$];
  sample_t monE;
  int      monDone;

  rx_data_sampler_if bus ();

  rx_data_sampler dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic waitCycle();
    @(posedge CLK);
    #1;
  endtask

  function automatic int effP(input logic [5:0] v);
    return (v == 6'd8 || v == 6'd16 || v == 6'd32) ? int'(v) : 8;
  endfunction

  // Monitor: every strobe and frame_done must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (bus.sample_valid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL strobe_unexpected cycle=%0d got bit=%0b bit_cnt=%0d edge_cnt=%0d, want no strobe",
                 cyc, bus.sampled_bit, bus.bit_cnt, bus.edge_cnt);
      end else begin
        monE = expQ.pop_front();
        if (cyc != monE.cycle || bus.sampled_bit !== monE.value ||
            bus.bit_cnt !== monE.bitIdx || bus.edge_cnt !== monE.edgeIdx) begin
          errors++;
          $display("[TB] FAIL strobe got cycle=%0d bit=%0b bit_cnt=%0d edge_cnt=%0d, want cycle=%0d bit=%0b bit_cnt=%0d edge_cnt=%0d",
                   cyc, bus.sampled_bit, bus.bit_cnt, bus.edge_cnt,
                   monE.cycle, monE.value, monE.bitIdx, monE.edgeIdx);
        end
      end
    end
    if (bus.frame_done === 1'b1) begin
      checks++;
      if (doneQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL frame_done_unexpected got cycle=%0d, want none", cyc);
      end else begin
        monDone = doneQ.pop_front();
        if (cyc != monDone) begin
          errors++;
          $display("[TB] FAIL frame_done got cycle=%0d, want cycle=%0d", cyc, monDone);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [5:0] expEdge, input logic [3:0] expBit,
                             input logic expValid, input logic expDone, input logic expSampled);
    checks++;
    if (bus.edge_cnt !== expEdge) begin
      errors++;
      $display("[TB] FAIL %s edge_cnt got %0d want %0d", name, bus.edge_cnt, expEdge);
    end
    checks++;
    if (bus.bit_cnt !== expBit) begin
      errors++;
      $display("[TB] FAIL %s bit_cnt got %0d want %0d", name, bus.bit_cnt, expBit);
    end
    checks++;
    if (bus.sample_valid !== expValid) begin
      errors++;
      $display("[TB] FAIL %s sample_valid got %0b want %0b", name, bus.sample_valid, expValid);
    end
    checks++;
    if (bus.frame_done !== expDone) begin
      errors++;
      $display("[TB] FAIL %s frame_done got %0b want %0b", name, bus.frame_done, expDone);
    end
    checks++;
    if (bus.sampled_bit !== expSampled) begin
      errors++;
      $display("[TB] FAIL %s sampled_bit got %0b want %0b", name, bus.sampled_bit, expSampled);
    end
  endtask

  // One frame: optional latch cycle, then nTicks enabled cycles; runTicks -1 = full frame, -2 = random abort.
  task automatic applyStimulus(input logic [5:0] presIn, input logic parIn, input bit useLatch,
                               input int runTicks, input int glitchMode, input logic [7:0] data,
                               input bit resetAtEnd);
    int      p, l, s, nTicks, off, base;
    logic    frameBits [0:10];
    logic    lineVal [0:351];
    logic    va, vb, vc, v;
    sample_t e;
    if (useLatch) begin
      bus.dat_samp_en = 1'b0;
      bus.Prescale    = presIn;
      bus.PAR_EN      = parIn;
      waitCycle();
      p = effP(presIn);
      l = 10 + int'(parIn);
    end else begin
      p = 8;
      l = 10;
    end
    s = cyc;
    frameBits[0] = 1'b0;
    for (int i = 0; i < 8; i++) frameBits[i+1] = data[i];
    frameBits[9]  = (l == 11) ? ^data : 1'b1;
    frameBits[10] = 1'b1;
    for (int t = 0; t < l * p; t++) begin
      v = frameBits[t / p];
      if (glitchMode == 1 && $urandom_range(0, 7) == 0) v = ~v;
      if (glitchMode == 2 && (t % p) == p / 2) v = ~v;
      lineVal[t] = v;
    end
    if (runTicks == -1) nTicks = l * p;
    else if (runTicks == -2) nTicks = $urandom_range(1, l * p - 1);
    else nTicks = runTicks;
`ifdef RX_SAMPLER_MAJORITY_EN
    off = p / 2 + 2;
`else
    off = p / 2 + 1;
`endif
    for (int b = 0; b < l; b++) begin
      base = b * p;
      if (base + off <= nTicks) begin
`ifdef RX_SAMPLER_MAJORITY_EN
        va = lineVal[base + p/2 - 1];
        vb = lineVal[base + p/2];
        vc = lineVal[base + p/2 + 1];
        v  = (va & vb) | (va & vc) | (vb & vc);
`else
        v = lineVal[base + p/2];
`endif
        e.cycle   = s + base + off;
        e.value   = v;
        e.bitIdx  = 4'(b);
        e.edgeIdx = 6'(off);
        expQ.push_back(e);
        lastBit = v;
      end
    end
    if (nTicks == l * p) doneQ.push_back(s + l * p);
    for (int t = 0; t < nTicks; t++) begin
      bus.dat_samp_en = 1'b1;
      bus.RX_IN       = lineVal[t];
      if (t == 3 * p) begin
        bus.Prescale = 6'd32;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.Prescale = 6'($urandom);
        bus.PAR_EN   = 1'($urandom);
      end
      waitCycle();
    end
    if (resetAtEnd) begin
      RST             = 1'b1;
      bus.dat_samp_en = 1'b1;
      bus.Prescale    = 6'd32;
      bus.PAR_EN      = 1'b1;
      waitCycle();
      RST     = 1'b0;
      lastBit = 1'b0;
      @(negedge CLK);
      checkOutput("reset_midframe", 6'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    end else begin
      bus.dat_samp_en = 1'b0;
      bus.RX_IN       = 1'($urandom);
      waitCycle();
      @(negedge CLK);
      checkOutput("idle", 6'd0, 4'd0, 1'b0, 1'b0, lastBit);
    end
  endtask

  initial begin
    logic [5:0] pres;
    RST             = 1'b1;
    bus.dat_samp_en = 1'b0;
    bus.RX_IN       = 1'b1;
    bus.Prescale    = 6'd8;
    bus.PAR_EN      = 1'b0;
    waitCycle();
    waitCycle();
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("after_reset", 6'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] directed frames");
    applyStimulus(6'd8, 1'b0, 1'b1, -1, 0, 8'h55, 1'b0);
    applyStimulus(6'd16, 1'b1, 1'b1, -1, 0, 8'($urandom), 1'b0);
    applyStimulus(6'd16, 1'b0, 1'b1, -1, 2, 8'hFF, 1'b0);
    applyStimulus(6'd8, 1'b0, 1'b1, -1, 0, 8'($urandom), 1'b0);
    applyStimulus(6'd32, 1'b0, 1'b1, -1, 0, 8'($urandom), 1'b0);
    applyStimulus(6'd12, 1'b1, 1'b1, -1, 0, 8'($urandom), 1'b0);
    applyStimulus(6'd16, 1'b0, 1'b1, 5 * 16 + 3, 0, 8'($urandom), 1'b1);
    applyStimulus(6'd0, 1'b0, 1'b0, -1, 1, 8'($urandom), 1'b0);
    applyStimulus(6'd16, 1'b1, 1'b1, 37, 0, 8'($urandom), 1'b0);

    $display("[TB] random frames");
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 4))
        0:       pres = 6'd8;
        1:       pres = 6'd16;
        2:       pres = 6'd32;
        3:       pres = 6'd12;
        default: pres = 6'($urandom);
      endcase
      applyStimulus(pres, 1'($urandom), 1'b1, ($urandom_range(0, 3) == 0) ? -2 : -1, 1,
                    8'($urandom), 1'b0);
    end

    for (int i = 0; i < 4; i++) waitCycle();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL strobes_missing got %0d pending want 0", expQ.size());
    end
    checks++;
    if (doneQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL frame_done_missing got %0d pending want 0", doneQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
